// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: groups the completion-side handshake and the CDB broadcast
// bus of cdb_arbiter.
//
// Handshake: comp_valid[i]/comp_ready[i] form a valid/ready pair per source.
// A transfer happens on a rising clock edge where both are high. comp_ready
// depends only on buffer occupancy. A producer that sees valid without ready
// must hold valid, tag and data stable until the transfer happens. The CDB
// side has no ready: cdb_valid is a one-cycle broadcast that consumers must
// take when it appears.
//
// Signals:
//   comp_valid/comp_tag/comp_data  producer -> arbiter, per-source packed
//   comp_ready                     arbiter -> producer, per source
//   cdb_valid/cdb_tag/cdb_data     broadcast result
//   cdb_src                        winning source index
//   rs_free                        one-hot RS entry release pulse
//   dbg_rr_ptr                     round-robin pointer, observation only
interface cdb_arbiter_if #(
  parameter int NUM_SRC = 5,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        comp_valid;
  logic [NUM_SRC*TAG_W-1:0]  comp_tag;
  logic [NUM_SRC*DATA_W-1:0] comp_data;
  logic [NUM_SRC-1:0]        comp_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;
  logic [NUM_SRC-1:0]        rs_free;
  logic [SRC_W-1:0]          dbg_rr_ptr;

  modport master (
    output comp_valid, comp_tag, comp_data,
    input  comp_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, rs_free, dbg_rr_ptr
  );

  modport slave (
    input  comp_valid, comp_tag, comp_data,
    output comp_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, rs_free, dbg_rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed results from NUM_SRC functional-unit slots in
// per-source FIFOs and broadcasts at most one per cycle on the common data
// bus, chosen round-robin. Each broadcast also pulses the one-hot rs_free
// vector for the reservation-station entry that matches the source.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset; clears FIFOs, pointer and outputs
//   flush  synchronous squash; empties FIFOs, drops enqueues, rr_ptr -> 0
//   bus    cdb_arbiter_if.slave (completion handshake + CDB outputs)
module cdb_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = TAG_W + DATA_W;

  logic [ENT_W-1:0]   mem    [NUM_SRC][DEPTH];
  logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
  logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
  logic [CNT_W-1:0]   count  [NUM_SRC];
  logic [SRC_W-1:0]   rr_ptr;

  logic [NUM_SRC-1:0] not_empty;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               grant_valid;
  logic [SRC_W-1:0]   grant_idx;
  logic [ENT_W-1:0]   head;

  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [SRC_W-1:0]   cdb_src_q;
  logic [NUM_SRC-1:0] rs_free_q;

  // Explicit wrap keeps DEPTH=1 (single-bit pointer stuck at 0) correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready uses the pre-pop count, so a full FIFO refuses even while popping.
  always_comb begin
    not_empty = '0;
    ready     = '0;
    push      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      not_empty[i] = (count[i] != '0);
      ready[i]     = (count[i] < CNT_W'(DEPTH));
      push[i]      = bus.comp_valid[i] && ready[i];
    end
  end

  // Round robin as two passes: sources at/after rr_ptr first, then the
  // sources below it (the wrapped part of the scan).
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && (SRC_W'(i) >= rr_ptr) && not_empty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!grant_valid && (SRC_W'(i) < rr_ptr) && not_empty[i]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(i);
      end
    end
  end

  always_comb begin
    pop  = grant_valid ? (NUM_SRC'(1) << grant_idx) : '0;
    head = mem[grant_idx][rd_ptr[grant_idx]];
  end

  // Per-source FIFO state. Flush discards pending pops and pushes alike.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset || flush) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= {bus.comp_tag[i*TAG_W +: TAG_W],
                                bus.comp_data[i*DATA_W +: DATA_W]};
          wr_ptr[i] <= next_ptr(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= next_ptr(rd_ptr[i]);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Registered broadcast. Tag/data/src hold on idle and flush cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rs_free_q   <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
      rs_free_q   <= '0;
      rr_ptr      <= '0;
    end else if (grant_valid) begin
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= head[ENT_W-1:DATA_W];
      cdb_data_q  <= head[DATA_W-1:0];
      cdb_src_q   <= grant_idx;
      rs_free_q   <= pop;
      rr_ptr      <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      cdb_valid_q <= 1'b0;
      rs_free_q   <= '0;
    end
  end

  assign bus.comp_ready = ready;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_tag    = cdb_tag_q;
  assign bus.cdb_data   = cdb_data_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.rs_free    = rs_free_q;
  assign bus.dbg_rr_ptr = rr_ptr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo_chk
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
      !(push[g] && (count[g] == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clock) disable iff (reset)
      !(pop[g] && !not_empty[g]));
    a_count_range: assert property (@(posedge clock) disable iff (reset)
      count[g] <= CNT_W'(DEPTH));
  end

  a_free_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(rs_free_q));
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by randomized traffic, every
// cycle compared against a queue-based reference of the arbitration rules.
module tb_cdb_arbiter;
  localparam int NUM_SRC = 5;
  localparam int DEPTH   = 2;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;
  localparam int ENT_W   = TAG_W + DATA_W;

  typedef logic [ENT_W-1:0] ent_t;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  logic flush;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  cdb_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // ---------------- scoreboard / reference ----------------
  int tests  = 0;
  int failed = 0;

  ent_t               exp_q [NUM_SRC][$];
  int                 m_rr;
  logic               e_valid;
  logic [TAG_W-1:0]   e_tag;
  logic [DATA_W-1:0]  e_data;
  int                 e_src;
  logic [NUM_SRC-1:0] e_free;
  logic               e_all;

  logic [NUM_SRC-1:0] drv_valid;
  logic [TAG_W-1:0]   drv_tag  [NUM_SRC];
  logic [DATA_W-1:0]  drv_data [NUM_SRC];
  logic               drv_flush;
  logic               drv_reset;
  logic [NUM_SRC-1:0] last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_SRC-1:0] model_ready();
    logic [NUM_SRC-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i] = (exp_q[i].size() < DEPTH);
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
    m_rr = 0;
  endfunction

  // What the next rising edge does, from the arbitration rules.
  function automatic void model_edge();
    int g;
    ent_t e;
    logic [NUM_SRC-1:0] acc;
    if (drv_reset) begin
      model_clear();
      e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = 0; e_free = '0; e_all = 1'b1;
      return;
    end
    e_all = 1'b0;
    if (drv_flush) begin
      model_clear();
      e_valid = 1'b0; e_free = '0;
      return;
    end
    acc = drv_valid & model_ready();
    g = -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (m_rr + k) % NUM_SRC;
      if (g < 0 && exp_q[idx].size() != 0) g = idx;
    end
    if (g >= 0) begin
      e = exp_q[g].pop_front();
      e_valid = 1'b1;
      e_tag   = e[ENT_W-1:DATA_W];
      e_data  = e[DATA_W-1:0];
      e_src   = g;
      e_free  = NUM_SRC'(1) << g;
      m_rr    = (g + 1) % NUM_SRC;
    end else begin
      e_valid = 1'b0;
      e_free  = '0;
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (acc[i]) exp_q[i].push_back({drv_tag[i], drv_data[i]});
  endfunction

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clock);
    reset = drv_reset;
    flush = drv_flush;
    bus.comp_valid = drv_valid;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.comp_tag[i*TAG_W +: TAG_W]    = drv_tag[i];
      bus.comp_data[i*DATA_W +: DATA_W] = drv_data[i];
    end
    last_ready = bus.comp_ready;
    check("comp_ready", bus.comp_ready, model_ready());
    model_edge();
    @(posedge clock);
    #1;
    check("cdb_valid", bus.cdb_valid, e_valid);
    check("rs_free", bus.rs_free, e_free);
    check("rr_ptr", bus.dbg_rr_ptr, m_rr);
    if (e_valid || e_all) begin
      check("cdb_tag", bus.cdb_tag, e_tag);
      check("cdb_data", bus.cdb_data, e_data);
      check("cdb_src", bus.cdb_src, e_src);
    end
  endtask

  task automatic idle_inputs();
    drv_valid = '0;
    drv_flush = 1'b0;
    drv_reset = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    drv_flush = 1'b1;
    cycle();
    drv_flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, gap, max_gap, grants40, ng, b;
    logic seen0, seen40, pushed40, saw_low, acc;
    logic [TAG_W-1:0] got [3];

    reset = 1'b1;
    flush = 1'b0;
    bus.comp_valid = '0;
    bus.comp_tag   = '0;
    bus.comp_data  = '0;
    model_clear();
    e_valid = 1'b0; e_tag = '0; e_data = '0; e_src = 0; e_free = '0; e_all = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      drv_tag[i]  = '0;
      drv_data[i] = '0;
    end
    idle_inputs();

    // Reset
    drv_reset = 1'b1;
    cycle();
    cycle();
    drv_reset = 1'b0;
    check("reset_ready", bus.comp_ready, 5'b11111);
    check("reset_valid", bus.cdb_valid, 1'b0);

    // Single result: one cycle in the queue
    drv_valid = 5'b00001; drv_tag[0] = 6'd5; drv_data[0] = 32'hDEAD;
    cycle();
    check("single_not_bypassed", bus.cdb_valid, 1'b0);
    idle_inputs();
    cycle();
    check("single_valid", bus.cdb_valid, 1'b1);
    check("single_tag", bus.cdb_tag, 6'd5);
    check("single_data", bus.cdb_data, 32'hDEAD);
    check("single_src", bus.cdb_src, 0);
    check("single_free", bus.rs_free, 5'b00001);
    cycle();
    check("single_idle_valid", bus.cdb_valid, 1'b0);
    check("single_idle_free", bus.rs_free, 5'b00000);

    // All five at once from rr_ptr=0
    do_flush();
    drv_valid = 5'b11111;
    for (int i = 0; i < NUM_SRC; i++) begin
      drv_tag[i]  = TAG_W'(i + 1);
      drv_data[i] = $urandom;
    end
    cycle();
    idle_inputs();
    for (int k = 0; k < NUM_SRC; k++) begin
      cycle();
      check("all5_tag", bus.cdb_tag, k + 1);
      check("all5_free", bus.rs_free, NUM_SRC'(1) << k);
    end
    check("all5_rr_end", bus.dbg_rr_ptr, 0);

    // Fairness: src0 streams, src3 pushes tag 40 once
    do_flush();
    t0 = 10; gap = 0; max_gap = 0; grants40 = 0;
    seen0 = 0; seen40 = 0; pushed40 = 0;
    for (int n = 0; n < 16; n++) begin
      drv_valid = (n == 2) ? 5'b01001 : 5'b00001;
      drv_tag[0] = TAG_W'(t0); drv_data[0] = $urandom;
      drv_tag[3] = 6'd40;      drv_data[3] = $urandom;
      acc = (exp_q[0].size() < DEPTH);
      cycle();
      if (acc) t0++;
      if (n == 2) pushed40 = 1;
      if (bus.cdb_valid && bus.cdb_src == 0) begin
        seen0 = 1; gap = 0;
      end else if (seen0) begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end
      if (n > 2 && pushed40 && !seen40 && bus.cdb_valid) begin
        grants40++;
        if (bus.cdb_tag == 6'd40) seen40 = 1;
      end
    end
    idle_inputs();
    check("fair_40_seen", seen40, 1'b1);
    check("fair_40_within_2", (grants40 <= 2), 1'b1);
    check("fair_src0_gap_le4", (max_gap <= 4), 1'b1);

    // Backpressure on src1 with src2 competing from rr_ptr=2
    do_flush();
    drv_valid = 5'b00010; drv_tag[1] = 6'd20;
    cycle();
    idle_inputs();
    cycle();
    check("bp_rr_start", bus.dbg_rr_ptr, 2);
    b = 0; ng = 0; saw_low = 0;
    for (int i = 0; i < 3; i++) got[i] = '0;
    for (int n = 0; n < 12; n++) begin
      drv_valid = '0;
      drv_valid[1] = (b < 3);
      drv_valid[2] = (n < 8);
      drv_tag[1] = TAG_W'(21 + b); drv_data[1] = $urandom;
      drv_tag[2] = TAG_W'(30 + n); drv_data[2] = $urandom;
      acc = drv_valid[1] && (exp_q[1].size() < DEPTH);
      cycle();
      if (drv_valid[1] && !last_ready[1]) saw_low = 1;
      if (acc) b++;
      if (bus.cdb_valid && bus.cdb_src == 1 && ng < 3) begin
        got[ng] = bus.cdb_tag;
        ng++;
      end
    end
    idle_inputs();
    check("bp_ready_dropped", saw_low, 1'b1);
    check("bp_count", ng, 3);
    check("bp_order0", got[0], 6'd21);
    check("bp_order1", got[1], 6'd22);
    check("bp_order2", got[2], 6'd23);

    // Flush with buffered results and a coincident src2 push
    do_flush();
    drv_valid = 5'b10001; drv_tag[0] = 6'd1; drv_tag[4] = 6'd2;
    cycle();
    drv_tag[0] = 6'd3; drv_tag[4] = 6'd4;
    cycle();
    drv_valid = 5'b00100; drv_tag[2] = 6'd9; drv_flush = 1'b1;
    cycle();
    idle_inputs();
    check("flush_valid", bus.cdb_valid, 1'b0);
    check("flush_free", bus.rs_free, 5'b00000);
    check("flush_rr", bus.dbg_rr_ptr, 0);
    for (int n = 0; n < 4; n++) begin
      cycle();
      check("flush_quiet", bus.cdb_valid, 1'b0);
    end
    check("flush_ready", bus.comp_ready, 5'b11111);

    // Reset mid-stream
    drv_valid = 5'b11111;
    for (int i = 0; i < NUM_SRC; i++) begin
      drv_tag[i]  = TAG_W'(50 + i);
      drv_data[i] = $urandom;
    end
    cycle();
    idle_inputs();
    cycle();
    check("rst_mid_busy", bus.cdb_valid, 1'b1);
    drv_reset = 1'b1;
    cycle();
    drv_reset = 1'b0;
    check("rst_mid_valid", bus.cdb_valid, 1'b0);
    check("rst_mid_tag", bus.cdb_tag, 6'd0);
    check("rst_mid_data", bus.cdb_data, 32'd0);
    check("rst_mid_src", bus.cdb_src, 0);
    check("rst_mid_free", bus.rs_free, 5'b00000);
    check("rst_mid_ready", bus.comp_ready, 5'b11111);
    drv_valid = 5'b01000; drv_tag[3] = 6'd7; drv_data[3] = 32'h1234_5678;
    cycle();
    idle_inputs();
    check("rst_after_wait", bus.cdb_valid, 1'b0);
    cycle();
    check("rst_after_valid", bus.cdb_valid, 1'b1);
    check("rst_after_tag", bus.cdb_tag, 6'd7);
    check("rst_after_data", bus.cdb_data, 32'h1234_5678);
    check("rst_after_free", bus.rs_free, 5'b01000);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drv_valid = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        drv_tag[i]  = TAG_W'($urandom);
        drv_data[i] = $urandom;
      end
      drv_flush = ($urandom_range(0, 39) == 0);
      drv_reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle_inputs();
    for (int n = 0; n < 12; n++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Collects completed results from the five functional-unit slots (ALU, LOAD, STORE, MULT0, MULT1) and buffers each source in a small FIFO. A round-robin arbiter picks at most one result per cycle and broadcasts it on the common data bus (CDB). The reservation station uses the CDB to wake up operands. The block also pulses a one-hot free vector that releases the matching reservation-station entry.

Parameters:
NUM_SRC, 5, number of completion sources; the source index equals the RS entry index.
DEPTH, 2, entries per source FIFO; must be a power of two and at least 1.
TAG_W, 6, physical-register tag width.
DATA_W, 32, result value width.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous squash; clears all buffered results.
comp_valid  input  NUM_SRC  per-source completion valid.
comp_tag  input  NUM_SRC*TAG_W  per-source destination tag; source i occupies bits [i*TAG_W +: TAG_W].
comp_data  input  NUM_SRC*DATA_W  per-source result; source i occupies bits [i*DATA_W +: DATA_W].
comp_ready  output  NUM_SRC  per-source "FIFO can accept" signal.
cdb_valid  output  1  a broadcast is valid this cycle.
cdb_tag  output  TAG_W  tag being broadcast.
cdb_data  output  DATA_W  value being broadcast.
cdb_src  output  $clog2(NUM_SRC)  index of the source that won.
rs_free  output  NUM_SRC  one-hot release pulse for the RS entry.

Behaviour:
- Reset: all FIFOs empty; rr_ptr=0; cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, rs_free=0. comp_ready is all ones after reset.
- Enqueue:
  - comp_ready[i] = (count[i] < DEPTH). It is a function of occupancy only, with no combinational path from grant or flush.
  - A handshake is comp_valid[i] && comp_ready[i] at the clock edge. It pushes {tag, data} to FIFO i.
  - comp_valid while not ready is ignored; the producer must hold it.
- Arbitration, each cycle, combinational over FIFO heads:
  - The grant is the first non-empty source scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC.
  - On a grant: pop that head. At the edge, register cdb_valid=1, cdb_tag/cdb_data=head, cdb_src=grant, rs_free=one-hot(grant). Set rr_ptr=(grant+1) mod NUM_SRC; the wrap from NUM_SRC-1 goes to 0.
  - With no grant: cdb_valid=0, rs_free=0, rr_ptr unchanged. cdb_tag, cdb_data and cdb_src hold their previous values and are don't-care.
- Latency:
  - A result accepted at edge k is at the FIFO head during the following cycle.
  - If granted, it is broadcast (cdb_valid high) after edge k+1, i.e. 1 cycle in the queue.
  - There is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO: both occur and count is unchanged. Because comp_ready uses the pre-pop count, a full FIFO does not accept even when it is being popped.
- Outputs are registered. cdb_valid and rs_free are single-cycle pulses per broadcast.
- Per-source order is FIFO order. There is no ordering across sources.
- Tag value 0 is treated as an ordinary tag.
- Flush:
  - At the edge where flush=1, all FIFOs are emptied.
  - The next-cycle cdb_valid=0 and rs_free=0; rr_ptr is reset to 0.
  - Enqueues in the flush cycle are dropped; flush wins.
- Reset mid-operation has the same effect as flush, plus every output is cleared. Reset has priority over flush.
- The FIFOs use wrapped read and write pointers of log2(DEPTH) bits plus a count of $clog2(DEPTH+1) bits. Overflow and underflow are impossible by construction; assertions check that.

Test Plan:
- Single result: src 0 sends tag=5, data=0xDEAD at edge 1 → cdb_valid=1, cdb_tag=5, cdb_data=0xDEAD, cdb_src=0, rs_free=5'b00001 in the cycle after edge 2; idle (cdb_valid=0, rs_free=0) afterwards.
- All five sources push together (tags 1..5) with rr_ptr=0 → broadcasts tag 1,2,3,4,5 on consecutive cycles; rs_free walks 00001→10000; rr_ptr ends at 0.
- Fairness: src 0 valid every cycle with tags 10,11,... and src 3 pushes tag 40 once → tag 40 is broadcast within 2 grants; src 0 is never starved for more than 4 cycles.
- Backpressure: src 1 pushes 3 results while src 2 holds continuous priority (rr_ptr at 2) → comp_ready[1] drops after 2 accepts; the third result is held until a pop; all 3 tags appear in push order.
- Flush: 2 results buffered in each of src 0 and src 4, then flush=1 coincident with a new comp_valid[2] → no broadcasts follow; comp_ready=all ones; rr_ptr=0; the src 2 result is lost.
- Reset mid-stream: assert reset while cdb_valid=1 → the next cycle has all outputs 0 and FIFOs empty; a new push after reset is broadcast with the normal 1-cycle queue latency.
